cdb_arbiter: RTL

Transmitting end of the common data bus. It collects completed results from up to NUM_FU functional units, buffers them in per-FU FIFOs, and selects one per cycle by round-robin. The winner drives a registered broadcast (cdb_valid/cdb_data/cdb_tag) to the reservation stations and ROB. Per-FU busy signals give backpressure to stage_ex (cdb_packet_busy), so an FU stalls instead of losing a result.

---
 rtl/cdb_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus transmitter: per-FU result FIFOs drained one entry per cycle
// by a round-robin arbiter into a registered broadcast.
module cdb_arbiter #(
    parameter int NUM_FU   = 4,
    parameter int DEPTH    = 2,
    parameter int TAG_BITS = 5,
    localparam int IDX_W   = $clog2(NUM_FU)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic [NUM_FU-1:0]          fu_valid_i,
    input  logic [NUM_FU*32-1:0]       fu_value_i,
    input  logic [NUM_FU*TAG_BITS-1:0] fu_tag_i,
    output logic [NUM_FU-1:0]          fu_busy_o,
    output logic                       cdb_valid_o,
    output logic [31:0]                cdb_data_o,
    output logic [TAG_BITS-1:0]        cdb_tag_o,
    output logic [IDX_W-1:0]           cdb_fu_idx_o,
    output logic                       overflow_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = 32 + TAG_BITS;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FU - 1);

    logic [ENT_W-1:0] mem_q   [NUM_FU][DEPTH];
    logic [PTR_W-1:0] head_q  [NUM_FU];
    logic [PTR_W-1:0] tail_q  [NUM_FU];
    logic [CNT_W-1:0] count_q [NUM_FU];
    logic [IDX_W-1:0] rr_ptr_q;

    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] enq;
    logic [NUM_FU-1:0] deq;
    logic              gnt_valid;
    logic [IDX_W-1:0]  gnt_idx;
    logic [ENT_W-1:0]  gnt_ent;
    int unsigned       scan_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            req[i]       = (count_q[i] != '0);
            fu_busy_o[i] = (count_q[i] == FULL_CNT);
            enq[i]       = fu_valid_i[i] && !fu_busy_o[i] && !flush_i;
        end
    end

    // First requester at or above rr_ptr, wrapping past the top index.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            scan_idx = 32'(rr_ptr_q) + k;
            if (scan_idx >= NUM_FU) scan_idx = scan_idx - NUM_FU;
            if (!gnt_valid && req[scan_idx[IDX_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = scan_idx[IDX_W-1:0];
            end
        end
        gnt_ent = mem_q[gnt_idx][head_q[gnt_idx]];
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            deq[i] = gnt_valid && (gnt_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (enq[i]) begin
                mem_q[i][tail_q[i]] <= {fu_value_i[i*32 +: 32], fu_tag_i[i*TAG_BITS +: TAG_BITS]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
            rr_ptr_q     <= '0;
            cdb_valid_o  <= 1'b0;
            cdb_data_o   <= '0;
            cdb_tag_o    <= '0;
            cdb_fu_idx_o <= '0;
            overflow_o   <= 1'b0;
        end else if (flush_i) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
            rr_ptr_q    <= '0;
            cdb_valid_o <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (enq[i]) tail_q[i] <= ptr_inc(tail_q[i]);
                if (deq[i]) head_q[i] <= ptr_inc(head_q[i]);
                if (enq[i] && !deq[i]) begin
                    count_q[i] <= count_q[i] + 1'b1;
                end else if (!enq[i] && deq[i]) begin
                    count_q[i] <= count_q[i] - 1'b1;
                end
                // Full is judged on pre-edge state, so a same-edge dequeue does not save the write.
                if (fu_valid_i[i] && fu_busy_o[i]) overflow_o <= 1'b1;
            end
            if (gnt_valid) begin
                cdb_valid_o  <= 1'b1;
                cdb_data_o   <= gnt_ent[ENT_W-1:TAG_BITS];
                cdb_tag_o    <= gnt_ent[TAG_BITS-1:0];
                cdb_fu_idx_o <= gnt_idx;
                rr_ptr_q     <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
            end else begin
                cdb_valid_o <= 1'b0;
            end
        end
    end

endmodule
